spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 185 ++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash read responder (0x03; 0x0B too when FAST_READ_EN is defined).
// Pins pass through 2-flop synchronizers; a byte fetch is issued one byte ahead so output bytes stream back to back.
module spi_flash_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        rd_en,
    output logic [23:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        active,
    output logic        bad_cmd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
`ifdef FAST_READ_EN
        S_DUMMY  = 3'd3,
`endif
        S_DATA   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic        r_cs_s1, r_cs_s2, r_cs_d;
    logic        r_mosi_s1, r_mosi_s2;
    logic [1:0]  r_warm;
    logic        r_cs_armed;
    logic [4:0]  r_bit_cnt;
    logic [22:0] r_shift;
    logic [7:0]  r_tx_buf, r_tx_sr;
    logic [2:0]  r_tx_cnt;
    logic        r_fetch_pend, r_miso, r_rd_en, r_bad_cmd;
    logic [23:0] r_rd_addr;
`ifdef FAST_READ_EN
    logic        r_fast;
`endif
    logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic        w_issue_first, w_issue_next, w_bad;
    logic [7:0]  w_opcode;
    logic [23:0] w_addr;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    // Armed only once cs_n has been seen high after reset, so a transaction cut by reset is never resumed.
    assign w_cs_fall   = r_cs_armed & r_cs_d & ~r_cs_s2;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
    assign w_opcode    = {r_shift[6:0], r_mosi_s2};
    assign w_addr      = {r_shift, r_mosi_s2};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_issue_first = 1'b0;
        w_issue_next  = 1'b0;
        w_bad         = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
                S_CMD: if (w_sclk_rise && r_bit_cnt == 5'd0) begin
                    if (w_opcode == 8'h03) w_state_nxt = S_ADDR;
`ifdef FAST_READ_EN
                    else if (w_opcode == 8'h0B) w_state_nxt = S_ADDR;
`endif
                    else begin
                        w_state_nxt = S_IGNORE;
                        w_bad       = 1'b1;
                    end
                end
                S_ADDR: if (w_sclk_rise && r_bit_cnt == 5'd0) begin
                    w_issue_first = 1'b1;
`ifdef FAST_READ_EN
                    w_state_nxt   = r_fast ? S_DUMMY : S_DATA;
`else
                    w_state_nxt   = S_DATA;
`endif
                end
`ifdef FAST_READ_EN
                S_DUMMY: if (w_sclk_rise && r_bit_cnt == 5'd0) w_state_nxt = S_DATA;
`endif
                // Rise sampling bit 7 of the current byte fetches the next one.
                S_DATA: if (w_sclk_rise && r_tx_cnt == 3'd7) w_issue_next = 1'b1;
                S_IGNORE: w_state_nxt = S_IGNORE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_sclk_s1, r_sclk_s2, r_sclk_d} <= 3'b000;
            {r_cs_s1, r_cs_s2, r_cs_d}       <= 3'b111;
            {r_mosi_s1, r_mosi_s2}           <= 2'b00;
            r_warm       <= 2'd0;
            r_cs_armed   <= 1'b0;
            r_bit_cnt    <= 5'd0;
            r_shift      <= 23'd0;
            r_tx_buf     <= 8'd0;
            r_tx_sr      <= 8'd0;
            r_tx_cnt     <= 3'd0;
            r_fetch_pend <= 1'b0;
            r_miso       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= 24'd0;
            r_bad_cmd    <= 1'b0;
`ifdef FAST_READ_EN
            r_fast       <= 1'b0;
`endif
        end else begin
            {r_sclk_s1, r_sclk_s2, r_sclk_d} <= {sclk, r_sclk_s1, r_sclk_s2};
            {r_cs_s1, r_cs_s2, r_cs_d}       <= {cs_n, r_cs_s1, r_cs_s2};
            {r_mosi_s1, r_mosi_s2}           <= {mosi, r_mosi_s1};
            if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
            r_cs_armed <= r_cs_armed | ((r_warm == 2'd2) & r_cs_s2);

            r_rd_en   <= w_issue_first | w_issue_next;
            r_bad_cmd <= w_bad;
            if (w_issue_first)     r_rd_addr <= w_addr;
            else if (w_issue_next) r_rd_addr <= r_rd_addr + 24'd1;
`ifdef FAST_READ_EN
            if (r_state == S_CMD && w_sclk_rise && r_bit_cnt == 5'd0)
                r_fast <= (w_opcode == 8'h0B);
`endif

            if (w_state_nxt == S_IDLE) begin
                r_bit_cnt <= 5'd0;
                r_shift   <= 23'd0;
            end else if (r_state == S_IDLE) begin
                r_bit_cnt <= 5'd7;
            end else if (w_sclk_rise && (r_state == S_CMD || r_state == S_ADDR
`ifdef FAST_READ_EN
                                         || r_state == S_DUMMY
`endif
                                         )) begin
                r_shift <= {r_shift[21:0], r_mosi_s2};
                if (r_bit_cnt != 5'd0)    r_bit_cnt <= r_bit_cnt - 5'd1;
                else if (r_state == S_CMD) r_bit_cnt <= 5'd23;
                else                       r_bit_cnt <= 5'd7;
            end

            // rd_data is valid the cycle after rd_en; hold it until the byte boundary fall.
            if (w_state_nxt == S_IDLE) begin
                r_fetch_pend <= 1'b0;
                r_tx_buf     <= 8'd0;
            end else begin
                r_fetch_pend <= r_rd_en;
                if (r_fetch_pend) r_tx_buf <= rd_data;
            end

            if (w_state_nxt != S_DATA) begin
                r_miso   <= 1'b0;
                r_tx_sr  <= 8'd0;
                r_tx_cnt <= 3'd0;
            end else if (r_state == S_DATA && w_sclk_fall) begin
                if (r_tx_cnt == 3'd0) begin
                    r_miso   <= r_tx_buf[7];
                    r_tx_sr  <= {r_tx_buf[6:0], 1'b0};
                    r_tx_cnt <= 3'd7;
                end else begin
                    r_miso   <= r_tx_sr[7];
                    r_tx_sr  <= {r_tx_sr[6:0], 1'b0};
                    r_tx_cnt <= r_tx_cnt - 3'd1;
                end
            end
        end
    end

    assign miso    = r_miso;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign bad_cmd = r_bad_cmd;
    assign active  = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboarded bench for spi_flash_responder: stimulus queues expected fetch addresses, bytes and bad_cmd pulses;
// monitors pop and compare as the responder produces them.
module tb_spi_flash_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic        miso, rd_en, active, bad_cmd;
    logic [23:0] rd_addr;
    logic [7:0]  rd_data = 8'hA5;

    int          n_vec = 0, n_err = 0;
    logic [23:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];
    int          exp_bad = 0;
    bit          rx_phase = 0;
    logic [7:0]  rx_sr = 8'd0;
    int          rx_cnt = 0;
    logic        prev_bad = 1'b0;

    spi_flash_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .active(active), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] store(input logic [23:0] a);
        return a[7:0];
    endfunction

    // Backing store: data valid only in the cycle after rd_en, garbage otherwise.
    always @(posedge clk) rd_data <= rd_en ? store(rd_addr) : 8'hA5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            check("rd_en_expected", exp_addr_q.size() > 0, 1);
            if (exp_addr_q.size() > 0) check("rd_addr", rd_addr, exp_addr_q.pop_front());
        end
        if (bad_cmd) begin
            check("bad_cmd_width", prev_bad, 0);
            check("bad_cmd_expected", exp_bad > 0, 1);
            if (exp_bad > 0) exp_bad--;
        end
        prev_bad = bad_cmd;
    end

    always @(posedge sclk) begin
        if (!cs_n && !rst) begin
            if (rx_phase) begin
                rx_sr = {rx_sr[6:0], miso};
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    check("miso_byte_expected", exp_byte_q.size() > 0, 1);
                    if (exp_byte_q.size() > 0) check("miso_byte", rx_sr, exp_byte_q.pop_front());
                end
            end else begin
                rx_cnt = 0;
                check("miso_idle", miso, 0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(12);
    endtask

    // n data bytes imply n+1 fetches: the last byte's bit-7 rise prefetches one more.
    task automatic read_tx(input logic [7:0] op, input logic [23:0] a, input int n, input bit dummy);
        for (int i = 0; i <= n; i++) exp_addr_q.push_back(a + 24'(i));
        for (int i = 0; i < n; i++) exp_byte_q.push_back(store(a + 24'(i)));
        cs_begin();
        spi_byte(op);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
        if (dummy) spi_byte(8'h00);
        rx_phase = 1;
        for (int i = 0; i < n; i++) spi_byte(8'hFF);
        rx_phase = 0;
        cs_end();
    endtask

    task automatic bad_tx(input logic [7:0] op);
        exp_bad++;
        cs_begin();
        spi_byte(op);
        spi_byte(8'h55);
        spi_byte(8'hAA);
        cs_end();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_bad_cmd"}, bad_cmd, 0);
    endtask

    initial begin
        wait_clk(4);
        check_outputs_zero("reset");
        rst = 1'b0;
        wait_clk(5);

        read_tx(8'h03, 24'h000100, 4, 1'b0);
        read_tx(8'h03, 24'hFFFFFE, 3, 1'b0);
        bad_tx(8'h9F);

        // Select with no clocks: nothing may be fetched or flagged.
        cs_n = 1'b0;
        wait_clk(20);
        check("active_cs_only", active, 1);
        cs_n = 1'b1;
        wait_clk(12);
        check("idle_after_cs_only", active, 0);

        // Abort after 12 address bits.
        cs_begin();
        spi_byte(8'h03);
        for (int i = 0; i < 12; i++) spi_bit(i[0]);
        wait_clk(HALF);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_active", active, 0);
        wait_clk(10);
        read_tx(8'h03, 24'h000010, 1, 1'b0);

        // Reset during the third data byte.
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(24'h000200 + 24'(i));
        exp_byte_q.push_back(8'h00);
        exp_byte_q.push_back(8'h01);
        cs_begin();
        spi_byte(8'h03);
        spi_byte(8'h00);
        spi_byte(8'h02);
        spi_byte(8'h00);
        rx_phase = 1;
        spi_byte(8'hFF);
        spi_byte(8'hFF);
        spi_bit(1'b1);
        spi_bit(1'b1);
        spi_bit(1'b1);
        rx_phase = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midrst");
        wait_clk(2);
        rst = 1'b0;
        wait_clk(20);
        // cs_n still low from before the reset: clocks here must not start a transaction.
        spi_byte(8'h03);
        wait_clk(4);
        check("no_resume_after_rst", active, 0);
        cs_n = 1'b1;
        wait_clk(12);
        read_tx(8'h03, 24'h000345, 2, 1'b0);

`ifdef FAST_READ_EN
        read_tx(8'h0B, 24'h000020, 2, 1'b1);
`else
        bad_tx(8'h0B);
`endif

        wait_clk(20);
        check("addr_queue_drained", exp_addr_q.size(), 0);
        check("byte_queue_drained", exp_byte_q.size(), 0);
        check("bad_cmd_drained", exp_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded 50000 clk cycles, expected completion");
        $fatal(1);
    end

endmodule
